mult32_seq: RTL and testbench
=============================

MULT32_SEQ -- requirements
Module: mult32_seq

Interface
REQ-001 Parameters: none; operand width fixed at 32, product width 64.
REQ-002 clk  input  1  rising-edge clock; all state updates on it.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  operand pair on a/b is valid.
REQ-005 in_ready  output  1  block can accept an operand pair.
REQ-006 a  input  32  multiplicand, unsigned.
REQ-007 b  input  32  multiplier, unsigned.
REQ-008 out_valid  output  1  product holds a completed result.
REQ-009 out_ready  input  1  consumer accepts the product.
REQ-010 product  output  64  unsigned product a*b.
REQ-011 busy  output  1  high while in RUN.

Function
REQ-012 The block SHALL be an unsigned shift-and-add multiplier.
- Each step's 32-bit addition SHALL use one FullAdder32bit instance with subtract tied to 0.
- The adder carryout SHALL be kept as bit 32 of the partial sum.
REQ-013 The FSM SHALL have exactly three states.
- IDLE: in_ready=1, out_valid=0, busy=0.
- RUN: in_ready=0, out_valid=0, busy=1.
- DONE: in_ready=0, out_valid=1, busy=0.
REQ-014 Transitions SHALL be:
- IDLE->RUN when in_valid=1 at a clock edge.
- RUN->DONE after the 32nd step.
- DONE->IDLE when out_ready=1 at a clock edge.
- Otherwise the state SHALL hold.
REQ-015 On acceptance the block SHALL:
- latch a into the multiplicand register M;
- load P_lo=b and P_hi=0;
- clear the step counter to 0.
REQ-016 Each RUN cycle SHALL perform one step:
- if P_lo[0]=1, {c,s} = P_hi + M, otherwise {c,s} = {0,P_hi};
- then {P_hi,P_lo} <= {c,s,P_lo} >> 1, a 65-bit logical right shift;
- then the counter SHALL increment.
REQ-017 RUN SHALL last exactly 32 cycles regardless of operand values, including zero operands.
- Accept at edge N gives out_valid=1 from edge N+33.
REQ-018 product SHALL equal {P_hi,P_lo} and SHALL be stable throughout DONE.
REQ-019 a and b SHALL be ignored outside the accepting edge; operand changes during RUN SHALL NOT affect the result.
REQ-020 in_valid SHALL be ignored in RUN and DONE; no input is queued.
REQ-021 Boundary conditions:
- If out_ready=1 and in_valid=1 in the same DONE cycle, the block SHALL only retire the result.
- A new operand pair is accepted no earlier than the following IDLE cycle.
- out_ready SHALL have no effect outside DONE.
- The 5-bit step counter SHALL NOT wrap into a 33rd step; the exit occurs on count 31.
REQ-022 All outputs SHALL be registered or decoded from registered state only, with no combinational input-to-output paths.

Reset
REQ-023 When reset=1 at a clock edge, the block SHALL enter IDLE and clear M, P_hi, P_lo and the counter to 0.
- Resulting outputs: in_ready=1, out_valid=0, busy=0, product=0.
REQ-024 Reset SHALL take priority over all handshakes, including reset asserted mid-RUN or in DONE.
- The in-flight result SHALL be discarded and out_valid SHALL NOT pulse.
REQ-025 in_valid=1 in the same cycle as reset SHALL NOT be accepted.

Verification
REQ-026 a=0xFFFFFFFF, b=0xFFFFFFFF, out_ready=1 -> out_valid 33 cycles after accept, product=0xFFFFFFFE00000001; carryout path exercised.
REQ-027 a=0xAAAAAAAA, b=0x00000002 -> product=0x0000000155555554.
REQ-028 a=0x00000028, b=0x00000004 -> product=0x00000000000000A0; a=0, b=0x12345678 -> product=0 after exactly 33 cycles.
REQ-029 Backpressure and input blocking:
- Stimulus: out_ready=0 for 10 cycles after out_valid rises, and in_valid=1 held throughout.
- Required: product and out_valid stable and in_ready=0 throughout.
- Required: one edge with out_ready=1 returns the block to IDLE with in_ready=1.
REQ-030 Reset mid-operation:
- Stimulus: reset asserted 15 cycles into RUN.
- Required: next cycle IDLE, product=0, out_valid never asserted.
- Required: a subsequent 3*5 completes with product=0x000000000000000F.
REQ-031 Operand isolation: change a/b every RUN cycle -> result equals the product of the values latched at acceptance.

Source files
------------

// File: rtl/mult32_seq.sv
// mult32_seq -- sequential 32x32 unsigned shift-and-add multiplier.
//
// One operand pair is accepted in IDLE, multiplied over exactly 32 RUN
// cycles (one partial-product step per cycle), and the 64-bit result is
// held in DONE until the consumer takes it.
//
// Ports:
//   clk       : rising-edge clock
//   reset     : synchronous, active-high reset
//   in_valid  : operand pair on a/b is valid
//   in_ready  : block can accept an operand pair (IDLE)
//   a         : 32-bit unsigned multiplicand
//   b         : 32-bit unsigned multiplier
//   out_valid : product holds a completed result (DONE)
//   out_ready : consumer accepts the product
//   product   : 64-bit unsigned product a*b
//   busy      : high while multiplying (RUN)

// FullAdder32bit -- 32-bit ripple-style adder/subtractor.
//   a, b      : 32-bit operands
//   subtract  : 1 computes a - b (two's complement), 0 computes a + b
//   sum       : 32-bit result
//   carryout  : carry out of bit 31
module FullAdder32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        subtract,
  output logic [31:0] sum,
  output logic        carryout
);

  logic [31:0] b_eff;

  always_comb begin
    b_eff              = b ^ {32{subtract}};
    {carryout, sum}    = {1'b0, a} + {1'b0, b_eff} + {32'd0, subtract};
  end

endmodule

module mult32_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] product,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [31:0] m;
  logic [31:0] p_hi;
  logic [31:0] p_lo;
  logic [4:0]  cnt;

  logic [31:0] addend;
  logic [31:0] add_sum;
  logic        add_carry;

  // Adding zero when the multiplier bit is clear yields {0, p_hi}, so a
  // single adder covers both cases of the step.
  assign addend = p_lo[0] ? m : '0;

  FullAdder32bit u_add (
    .a        (p_hi),
    .b        (addend),
    .subtract (1'b0),
    .sum      (add_sum),
    .carryout (add_carry)
  );

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (in_valid)            state_next = RUN;
      RUN:  if (cnt == 5'd31)        state_next = DONE;
      DONE: if (out_ready)           state_next = IDLE;
      default:                       state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      m     <= '0;
      p_hi  <= '0;
      p_lo  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            m    <= a;
            p_hi <= '0;
            p_lo <= b;
            cnt  <= '0;
          end
        end
        RUN: begin
          // 65-bit logical right shift of {carry, sum, p_lo}
          {p_hi, p_lo} <= {add_carry, add_sum, p_lo[31:1]};
          cnt          <= cnt + 5'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state == IDLE);
    busy      = (state == RUN);
    out_valid = (state == DONE);
    product   = {p_hi, p_lo};
  end

endmodule

// File: tb/tb_mult32_seq.sv
// tb_mult32_seq -- self-checking bench for mult32_seq.
// Expected products come from plain 64-bit arithmetic on the operands
// presented at acceptance; timing expectations from the handshake rules.
module tb_mult32_seq;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] product;
  logic        busy;

  int tests;
  int fails;

  mult32_seq dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full transaction: accept, 32 RUN cycles, optional backpressure, retire.
  task automatic do_mult(input logic [31:0] av, input logic [31:0] bv,
                         input bit scramble, input int unsigned hold,
                         input bit keep_valid, input string name);
    logic [63:0] expv;
    logic [63:0] held;
    int unsigned lat;
    bit run_bad;
    bit hold_bad;
    expv = {32'd0, av} * {32'd0, bv};
    a = av;
    b = bv;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    tick();                              // accepting edge N
    if (!keep_valid) in_valid = 1'b0;
    lat = 0;
    run_bad = 1'b0;
    while (!out_valid && lat < 40) begin
      if (busy !== 1'b1 || in_ready !== 1'b0) run_bad = 1'b1;
      if (scramble) begin
        a = $urandom;
        b = $urandom;
      end
      out_ready = 1'($urandom_range(0, 1));  // must be ignored in RUN
      tick();
      lat++;
    end
    out_ready = 1'b0;
    tests++;
    if (run_bad) begin
      fails++;
      $display("FAIL %s run_flags busy/in_ready wrong during RUN, required busy=1 in_ready=0", name);
    end
    // out_valid becomes 1 after edge N+32, i.e. sampled high at edge N+33
    tests++;
    if (lat !== 32) begin
      fails++;
      $display("FAIL %s latency got %0d edges, required 32", name, lat);
    end
    tests++;
    if (product !== expv) begin
      fails++;
      $display("FAIL %s product got %h, required %h", name, product, expv);
    end
    tests++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
      fails++;
      $display("FAIL %s done_flags got busy=%b in_ready=%b out_valid=%b, required 0 0 1",
               name, busy, in_ready, out_valid);
    end
    held = product;
    hold_bad = 1'b0;
    for (int unsigned i = 0; i < hold; i++) begin
      a = $urandom;
      b = $urandom;
      tick();
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || product !== held) hold_bad = 1'b1;
    end
    if (hold != 0) begin
      tests++;
      if (hold_bad) begin
        fails++;
        $display("FAIL %s backpressure got unstable output/in_ready, required product %h held", name, held);
      end
    end
    out_ready = 1'b1;
    tick();                              // retire edge; in_valid may still be 1
    out_ready = 1'b0;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL %s retire got in_ready=%b out_valid=%b busy=%b, required 1 0 0",
               name, in_ready, out_valid, busy);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = 1'b1;                    // must not be accepted under reset
    out_ready = 1'b0;
    a = 32'h1234_5678;
    b = 32'h9abc_def0;
    tick();
    tick();
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || product !== 64'd0) begin
      fails++;
      $display("FAIL reset_state got in_ready=%b out_valid=%b busy=%b product=%h, required 1 0 0 0",
               in_ready, out_valid, busy, product);
    end
    in_valid = 1'b0;
    reset    = 1'b0;
    tick();
    tests++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_no_accept got in_ready=%b busy=%b, required 1 0", in_ready, busy);
    end
  endtask

  task automatic test_directed();
    do_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 1'b0, "max_x_max");
    do_mult(32'hAAAA_AAAA, 32'h0000_0002, 1'b0, 0, 1'b0, "aa_x_2");
    do_mult(32'h0000_0028, 32'h0000_0004, 1'b0, 0, 1'b0, "28_x_4");
    do_mult(32'h0000_0000, 32'h1234_5678, 1'b0, 0, 1'b0, "zero_x_b");
    do_mult(32'h1234_5678, 32'h0000_0000, 1'b0, 0, 1'b0, "a_x_zero");
  endtask

  task automatic test_random_isolation();
    for (int i = 0; i < 12; i++)
      do_mult($urandom, $urandom, 1'b1, 0, 1'b0, "random_isolated");
  endtask

  task automatic test_backpressure();
    do_mult(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0, 10, 1'b1, "backpressure");
  endtask

  task automatic test_reset_mid();
    bit seen;
    a = 32'd7;
    b = 32'd9;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (15) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || product !== 64'd0) begin
      fails++;
      $display("FAIL reset_mid got in_ready=%b busy=%b out_valid=%b product=%h, required 1 0 0 0",
               in_ready, busy, out_valid, product);
    end
    seen = 1'b0;
    repeat (40) begin
      tick();
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    tests++;
    if (seen) begin
      fails++;
      $display("FAIL reset_mid_no_pulse got out_valid=1 after reset, required 0");
    end
    do_mult(32'd3, 32'd5, 1'b0, 0, 1'b0, "after_reset_3x5");
  endtask

  initial begin
    tests = 0;
    fails = 0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    reset = 1'b1;
    test_reset();
    test_directed();
    test_random_isolation();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
